// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the MEM-stage port.
// One outstanding transaction; data has priority, bounded by a starvation guard.
module sram_bus_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_req,
   input  logic            inst_wr,
   input  logic [1:0]      inst_size,
   input  logic [AW-1:0]   inst_addr,
   input  logic [DW-1:0]   inst_wdata,
   output logic            inst_addr_ok,
   output logic            inst_data_ok,
   output logic [DW-1:0]   inst_rdata,
   input  logic            data_req,
   input  logic            data_wr,
   input  logic [1:0]      data_size,
   input  logic [DW/8-1:0] data_wstrb,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic            data_addr_ok,
   output logic            data_data_ok,
   output logic [DW-1:0]   data_rdata,
   output logic            bus_req,
   output logic            bus_wr,
   output logic [1:0]      bus_size,
   output logic [DW/8-1:0] bus_wstrb,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   input  logic            bus_addr_ok,
   input  logic            bus_data_ok,
   input  logic [DW-1:0]   bus_rdata,
   output logic            busy
);

   localparam int SW = DW / 8;
   localparam int RW = $clog2(MAX_DATA_RUN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic          owner;
   logic [RW-1:0] run;
   logic          any_req;
   logic          run_full;
   logic          grant_data;
   logic          grant;

   assign any_req    = inst_req | data_req;
   assign run_full   = (run == RW'(MAX_DATA_RUN));
   assign grant_data = data_req & (~inst_req | ~run_full);
   assign grant      = (state == IDLE) & any_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req)     state_nx = ADDR;
         ADDR:    if (bus_addr_ok) state_nx = DATA;
         DATA:    if (bus_data_ok) state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

   // owner: 1 = data port, 0 = inst port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= 1'b0;
         run       <= '0;
         bus_wr    <= 1'b0;
         bus_size  <= 2'd0;
         bus_wstrb <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else if (grant) begin
         owner <= grant_data;
         if (grant_data & inst_req) begin
            run <= run_full ? run : run + RW'(1);
         end else begin
            run <= '0;
         end
         if (grant_data) begin
            bus_wr    <= data_wr;
            bus_size  <= data_size;
            bus_wstrb <= data_wstrb;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
         end else begin
            bus_wr    <= inst_wr;
            bus_size  <= inst_size;
            bus_wstrb <= {SW{inst_wr}};
            bus_addr  <= inst_addr;
            bus_wdata <= inst_wdata;
         end
      end
   end

   always_comb begin
      bus_req      = 1'b0;
      busy         = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      unique case (1'b1)
         (state == ADDR): begin
            bus_req      = 1'b1;
            busy         = 1'b1;
            inst_addr_ok = bus_addr_ok & ~owner;
            data_addr_ok = bus_addr_ok & owner;
         end
         (state == DATA): begin
            busy         = 1'b1;
            inst_data_ok = bus_data_ok & ~owner;
            data_data_ok = bus_data_ok & owner;
         end
         default: ;
      endcase
   end

   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter.
// Inputs change at posedge+1; outputs are checked before the next edge.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int pulses;

   always #5 clk = ~clk;

   sram_bus_arbiter #(.AW(32), .DW(32), .MAX_DATA_RUN(4)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full IDLE->ADDR->DATA->IDLE pass with the bus always ready.
   task automatic grant_cycle(input logic exp_data, input string tag);
      tick();
      #1;
      chk({tag, "_daok"}, 32'(data_addr_ok), 32'(exp_data));
      chk({tag, "_iaok"}, 32'(inst_addr_ok), 32'(!exp_data));
      tick();
      #1;
      chk({tag, "_ddok"}, 32'(data_data_ok), 32'(exp_data));
      chk({tag, "_idok"}, 32'(inst_data_ok), 32'(!exp_data));
      tick();
   endtask

   initial begin
      rst = 1'b0;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2;
      inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
      data_addr = 0; data_wdata = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

      // reset state
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_breq", 32'(bus_req), 32'd0);
      chk("rst_baddr", bus_addr, 32'd0);
      chk("rst_bwstrb", 32'(bus_wstrb), 32'd0);
      rst = 1'b1;
      tick();

      // 1: single inst read
      inst_req = 1; inst_addr = 32'h1C00_0000;
      #1;
      chk("t1_breq_idle", 32'(bus_req), 32'd0);
      tick();
      chk("t1_breq", 32'(bus_req), 32'd1);
      chk("t1_baddr", bus_addr, 32'h1C00_0000);
      chk("t1_bwr", 32'(bus_wr), 32'd0);
      chk("t1_bwstrb", 32'(bus_wstrb), 32'd0);
      bus_addr_ok = 1;
      #1;
      chk("t1_iaok", 32'(inst_addr_ok), 32'd1);
      chk("t1_daok", 32'(data_addr_ok), 32'd0);
      inst_req = 0;
      tick();
      bus_addr_ok = 0;
      #1;
      chk("t1_breq_data", 32'(bus_req), 32'd0);
      chk("t1_busy_data", 32'(busy), 32'd1);
      chk("t1_idok_early", 32'(inst_data_ok), 32'd0);
      tick();
      bus_data_ok = 1; bus_rdata = 32'h02C0_0000;
      #1;
      chk("t1_idok", 32'(inst_data_ok), 32'd1);
      chk("t1_irdata", inst_rdata, 32'h02C0_0000);
      chk("t1_ddok", 32'(data_data_ok), 32'd0);
      tick();
      bus_data_ok = 0;
      #1;
      chk("t1_idle", 32'(busy), 32'd0);

      // 2: data write with addr_ok delayed 5 cycles
      data_req = 1; data_wr = 1; data_addr = 32'h80;
      data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
      pulses = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         if (data_addr_ok) pulses++;
         chk("t2_bwr", 32'(bus_wr), 32'd1);
         chk("t2_bwdata", bus_wdata, 32'hDEAD_BEEF);
         chk("t2_breq", 32'(bus_req), 32'd1);
         tick();
      end
      chk("t2_bwstrb", 32'(bus_wstrb), 32'hF);
      chk("t2_baddr", bus_addr, 32'h80);
      bus_addr_ok = 1;
      #1;
      if (data_addr_ok) pulses++;
      data_req = 0;
      tick();
      bus_addr_ok = 0;
      #1;
      if (data_addr_ok) pulses++;
      chk("t2_aok_pulses", 32'(pulses), 32'd1);
      bus_data_ok = 1;
      #1;
      chk("t2_ddok", 32'(data_data_ok), 32'd1);
      chk("t2_idok", 32'(inst_data_ok), 32'd0);
      tick();
      bus_data_ok = 0; data_wr = 0; data_wstrb = 0;

      // 3: both held, bus always ready
      inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
      grant_cycle(1, "t3_g0");
      grant_cycle(1, "t3_g1");
      grant_cycle(1, "t3_g2");
      grant_cycle(1, "t3_g3");
      grant_cycle(0, "t3_g4");
      grant_cycle(1, "t3_g5");
      grant_cycle(1, "t3_g6");
      grant_cycle(1, "t3_g7");
      grant_cycle(1, "t3_g8");
      grant_cycle(0, "t3_g9");

      // 4: reset in DATA after run reaches 4
      grant_cycle(1, "t4_pre0");
      grant_cycle(1, "t4_pre1");
      grant_cycle(1, "t4_pre2");
      bus_data_ok = 0;
      tick();
      chk("t4_daok", 32'(data_addr_ok), 32'd1);
      tick();
      chk("t4_busy_data", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("t4_busy_rst", 32'(busy), 32'd0);
      chk("t4_breq_rst", 32'(bus_req), 32'd0);
      bus_data_ok = 1;
      #1;
      chk("t4_ddok_rst", 32'(data_data_ok), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      grant_cycle(1, "t4_g0");
      grant_cycle(1, "t4_g1");
      grant_cycle(1, "t4_g2");
      grant_cycle(1, "t4_g3");
      grant_cycle(0, "t4_g4");
      inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
      tick();

      // 5: bus_data_ok while in ADDR is ignored
      inst_req = 1; inst_addr = 32'h200;
      tick();
      bus_data_ok = 1;
      #1;
      chk("t5_idok_addr", 32'(inst_data_ok), 32'd0);
      chk("t5_ddok_addr", 32'(data_data_ok), 32'd0);
      tick();
      chk("t5_breq_hold", 32'(bus_req), 32'd1);
      chk("t5_iaok_hold", 32'(inst_addr_ok), 32'd0);
      bus_data_ok = 0; bus_addr_ok = 1;
      #1;
      chk("t5_iaok", 32'(inst_addr_ok), 32'd1);
      inst_req = 0;
      tick();
      bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h5A5A_0001;
      #1;
      chk("t5_idok", 32'(inst_data_ok), 32'd1);
      chk("t5_irdata", inst_rdata, 32'h5A5A_0001);
      tick();
      bus_data_ok = 0;

      // 6: addr_ok stall while data raises a request
      inst_req = 1; inst_wr = 1; inst_addr = 32'h40;
      inst_wdata = 32'h1234_5678;
      tick();
      data_req = 1; data_addr = 32'h900; data_wdata = 32'hCAFE_F00D;
      data_wr = 1; data_wstrb = 4'h3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_baddr", bus_addr, 32'h40);
         chk("t6_bwstrb", 32'(bus_wstrb), 32'hF);
         chk("t6_bwdata", bus_wdata, 32'h1234_5678);
         chk("t6_daok", 32'(data_addr_ok), 32'd0);
         tick();
      end
      bus_addr_ok = 1;
      #1;
      chk("t6_iaok", 32'(inst_addr_ok), 32'd1);
      chk("t6_daok_ack", 32'(data_addr_ok), 32'd0);
      inst_req = 0; inst_wr = 0;
      tick();
      bus_addr_ok = 0; bus_data_ok = 1;
      #1;
      chk("t6_idok", 32'(inst_data_ok), 32'd1);
      chk("t6_ddok", 32'(data_data_ok), 32'd0);
      tick();
      bus_data_ok = 0;
      tick();
      chk("t6_next_addr", bus_addr, 32'h900);
      chk("t6_next_wstrb", 32'(bus_wstrb), 32'h3);
      bus_addr_ok = 1;
      #1;
      chk("t6_next_daok", 32'(data_addr_ok), 32'd1);
      data_req = 0;
      tick();
      bus_addr_ok = 0; bus_data_ok = 1;
      tick();
      bus_data_ok = 0;
      #1;
      chk("t6_end_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
